// File: rtl/alu_exec.sv
// EX-stage execution unit: single-cycle ALU/branch/CSR ops, iterative
// shift-add multiplier, and the 64-bit cycle/instret counters.
module alu_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            retire,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);
    localparam int unsigned CW = 5;
    localparam int unsigned SW = 5;
    localparam int unsigned DW = 2 * XLEN;

    localparam logic [CW-1:0] OP_ADD       = 5'd0;
    localparam logic [CW-1:0] OP_SUB       = 5'd1;
    localparam logic [CW-1:0] OP_SLL       = 5'd2;
    localparam logic [CW-1:0] OP_SLT       = 5'd3;
    localparam logic [CW-1:0] OP_SLTU      = 5'd4;
    localparam logic [CW-1:0] OP_XOR       = 5'd5;
    localparam logic [CW-1:0] OP_SRL       = 5'd6;
    localparam logic [CW-1:0] OP_SRA       = 5'd7;
    localparam logic [CW-1:0] OP_OR        = 5'd8;
    localparam logic [CW-1:0] OP_AND       = 5'd9;
    localparam logic [CW-1:0] OP_BEQ       = 5'd10;
    localparam logic [CW-1:0] OP_BNE       = 5'd11;
    localparam logic [CW-1:0] OP_BLT       = 5'd12;
    localparam logic [CW-1:0] OP_BGE       = 5'd13;
    localparam logic [CW-1:0] OP_BLTU      = 5'd14;
    localparam logic [CW-1:0] OP_BGEU      = 5'd15;
    localparam logic [CW-1:0] OP_LUI       = 5'd16;
    localparam logic [CW-1:0] OP_MUL       = 5'd17;
    localparam logic [CW-1:0] OP_MULH      = 5'd18;
    localparam logic [CW-1:0] OP_MULHSU    = 5'd19;
    localparam logic [CW-1:0] OP_MULHU     = 5'd20;
    localparam logic [CW-1:0] OP_RDINSTRETH = 5'd21;
    localparam logic [CW-1:0] OP_RDINSTRET = 5'd22;
    localparam logic [CW-1:0] OP_RDCYCLEH  = 5'd23;
    localparam logic [CW-1:0] OP_RDCYCLE   = 5'd24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   cycle_cnt, instret_cnt;
    logic [DW-1:0]   acc, mcand;
    logic [XLEN-1:0] mplier;
    logic [SW-1:0]   iter;
    logic            mul_neg, mul_hi;

    logic            accept_c, is_mul_c, taken_c, s1_neg_c, s2_neg_c;
    logic [SW-1:0]   shamt_c;
    logic [XLEN-1:0] alu_res_c, mag1_c, mag2_c;
    logic [DW-1:0]   prod_c;

    assign in_ready  = ~rst & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    assign out_valid = (state == S_DONE);
    assign accept_c  = in_valid & in_ready;
    assign shamt_c   = src2[SW-1:0];
    assign is_mul_c  = (alu_ctrl == OP_MUL) | (alu_ctrl == OP_MULH) |
                       (alu_ctrl == OP_MULHSU) | (alu_ctrl == OP_MULHU);
    assign s1_neg_c  = src1[XLEN-1] & ((alu_ctrl == OP_MULH) | (alu_ctrl == OP_MULHSU));
    assign s2_neg_c  = src2[XLEN-1] & (alu_ctrl == OP_MULH);
    assign mag1_c    = s1_neg_c ? -src1 : src1;
    assign mag2_c    = s2_neg_c ? -src2 : src2;
    assign prod_c    = mul_neg ? -acc : acc;

    // Branch compare outcome
    always_comb begin
        taken_c = 1'b0;
        case (alu_ctrl)
            OP_BEQ:  taken_c = (src1 == src2);
            OP_BNE:  taken_c = (src1 != src2);
            OP_BLT:  taken_c = ($signed(src1) <  $signed(src2));
            OP_BGE:  taken_c = ($signed(src1) >= $signed(src2));
            OP_BLTU: taken_c = (src1 <  src2);
            OP_BGEU: taken_c = (src1 >= src2);
            default: taken_c = 1'b0;
        endcase
    end

    // Single-cycle result mux; counters are read before this edge's increment
    always_comb begin
        alu_res_c = '0;
        case (alu_ctrl)
            OP_ADD:        alu_res_c = src1 + src2;
            OP_SUB:        alu_res_c = src1 - src2;
            OP_SLL:        alu_res_c = src1 << shamt_c;
            OP_SLT:        alu_res_c = XLEN'($signed(src1) < $signed(src2));
            OP_SLTU:       alu_res_c = XLEN'(src1 < src2);
            OP_XOR:        alu_res_c = src1 ^ src2;
            OP_SRL:        alu_res_c = src1 >> shamt_c;
            OP_SRA:        alu_res_c = XLEN'($signed(src1) >>> shamt_c);
            OP_OR:         alu_res_c = src1 | src2;
            OP_AND:        alu_res_c = src1 & src2;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                           alu_res_c = XLEN'(taken_c);
            OP_LUI:        alu_res_c = src2;
            OP_RDINSTRETH: alu_res_c = instret_cnt[DW-1:XLEN];
            OP_RDINSTRET:  alu_res_c = instret_cnt[XLEN-1:0];
            OP_RDCYCLEH:   alu_res_c = cycle_cnt[DW-1:XLEN];
            OP_RDCYCLE:    alu_res_c = cycle_cnt[XLEN-1:0];
            default:       alu_res_c = '0;
        endcase
    end

    // Next-state logic; a DONE-state accept follows the IDLE rules
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept_c) state_nx = is_mul_c ? S_MUL : S_DONE;
            S_MUL:  if (iter == SW'(XLEN - 1)) state_nx = S_SIGN;
            S_SIGN: state_nx = S_DONE;
            S_DONE: begin
                if (accept_c)       state_nx = is_mul_c ? S_MUL : S_DONE;
                else if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Result capture and shift-add multiplier datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            branch_taken <= 1'b0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            iter         <= '0;
            mul_neg      <= 1'b0;
            mul_hi       <= 1'b0;
        end else if (accept_c) begin
            if (is_mul_c) begin
                acc     <= '0;
                mcand   <= DW'(mag1_c);
                mplier  <= mag2_c;
                iter    <= '0;
                mul_neg <= s1_neg_c ^ s2_neg_c;
                mul_hi  <= (alu_ctrl != OP_MUL);
            end else begin
                result       <= alu_res_c;
                branch_taken <= taken_c;
            end
        end else if (state == S_MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            iter   <= iter + SW'(1);
        end else if (state == S_SIGN) begin
            result       <= mul_hi ? prod_c[DW-1:XLEN] : prod_c[XLEN-1:0];
            branch_taken <= 1'b0;
        end
    end

    // Free-running cycle counter and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + DW'(1);
            instret_cnt <= instret_cnt + DW'(retire);
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed corner cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, retire, out_valid, out_ready, branch_taken;
    logic [4:0]  alu_ctrl;
    logic [31:0] src1, src2, result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel_cyc = 0;
    bit rnd_mode = 0;
    bit shown    = 0;
    logic [63:0] m_cyc = 0, m_ins = 0;

    typedef struct {
        logic [31:0] res;
        logic        tk;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t q[$];

    alu_exec #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src1(src1), .src2(src2), .retire(retire),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference counters: cycles and retirements since reset
    always @(posedge clk) begin
        if (rst) begin
            m_cyc <= 64'd0;
            m_ins <= 64'd0;
        end else begin
            m_cyc <= m_cyc + 64'd1;
            m_ins <= m_ins + 64'(retire);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                      input logic [63:0] cy, input logic [63:0] ins,
                                      output logic [31:0] r, output logic t);
        logic signed [63:0] p;
        logic [63:0] u;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        r = 32'd0;
        t = 1'b0;
        p = 64'sd0;
        u = 64'd0;
        case (c)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << b[4:0];
            5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> b[4:0];
            5'd7:  r = sa >>> b[4:0];
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: t = (a == b);
            5'd11: t = (a != b);
            5'd12: t = (sa < sb);
            5'd13: t = (sa >= sb);
            5'd14: t = (a < b);
            5'd15: t = (a >= b);
            5'd16: r = b;
            5'd17: begin u = {32'd0, a} * {32'd0, b}; r = u[31:0]; end
            5'd18: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
            5'd19: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); r = p[63:32]; end
            5'd20: begin u = {32'd0, a} * {32'd0, b}; r = u[63:32]; end
            5'd21: r = ins[63:32];
            5'd22: r = ins[31:0];
            5'd23: r = cy[63:32];
            5'd24: r = cy[31:0];
            default: r = 32'd0;
        endcase
        if (c >= 5'd10 && c <= 5'd15) r = {31'd0, t};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic jitter();
        if (rnd_mode) begin
            out_ready = ($urandom_range(3) != 0);
            retire    = 1'($urandom_range(1));
        end
    endtask

    // Present one op from a falling edge; push the expected response on accept
    task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input bit has_exp, input logic [31:0] er, input logic et);
        exp_t e;
        int waitc = 0;
        jitter();
        in_valid = 1'b1;
        alu_ctrl = code;
        src1 = a;
        src2 = b;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            jitter();
            #1;
            waitc++;
            if (waitc > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stuck 0 for op %0d", code);
                in_valid = 1'b0;
                return;
            end
        end
        if (has_exp) begin
            e.res = er;
            e.tk  = et;
        end else begin
            ref_model(code, a, b, m_cyc, m_ins, e.res, e.tk);
        end
        e.acc_cyc = cyc;
        e.lat = (code >= 5'd17 && code <= 5'd20) ? 34 : 1;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: checks latency on first presentation, value on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                shown = 0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: result 0x%0h with nothing pending (cycle %0d)", result, cyc);
                end else begin
                    if (!shown) begin
                        shown = 1;
                        chk("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
                    end
                    if (out_ready) begin
                        chk("result", 64'(result), 64'(q[0].res));
                        chk("branch_taken", 64'(branch_taken), 64'(q[0].tk));
                        void'(q.pop_front());
                        shown = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] c;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; retire = 1'b1;
        alu_ctrl = 5'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        retire = 1'b0;
        rel_cyc = cyc;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_branch_taken", 64'(branch_taken), 64'd0);

        // Counters
        issue(5'd24, 32'd0, 32'd0, 1, 32'd0, 1'b0);
        repeat (3) begin
            retire = 1'b1;
            @(negedge clk);
            retire = 1'b0;
            @(negedge clk);
        end
        issue(5'd22, 32'd0, 32'd0, 1, 32'd3, 1'b0);
        while (cyc - rel_cyc < 20) @(negedge clk);
        issue(5'd24, 32'd0, 32'd0, 1, 32'd20, 1'b0);

        // Directed single-cycle corners
        issue(5'd0,  32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1'b0);
        issue(5'd1,  32'd0, 32'd1, 1, 32'hFFFF_FFFF, 1'b0);
        issue(5'd7,  32'h8000_0000, 32'd31, 1, 32'hFFFF_FFFF, 1'b0);
        issue(5'd12, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b1);
        issue(5'd14, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
        issue(5'd10, 32'd5, 32'd5, 1, 32'd1, 1'b1);
        issue(5'd16, 32'd9, 32'hABCD_E000, 1, 32'hABCD_E000, 1'b0);

        // Directed multiplies
        issue(5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 1'b0);
        issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001, 1'b0);
        issue(5'd18, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 1'b0);
        issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0);
        drain();

        // Backpressure: result held, no accept until out_ready rises
        out_ready = 1'b0;
        issue(5'd0, 32'd1, 32'd2, 1, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            alu_ctrl = 5'd5;
            src1 = 32'hF0F0_F0F0;
            src2 = 32'h0FF0_0FF0;
            #1;
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_result", 64'(result), 64'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFF00_FF00, 1'b0);
        drain();

        // Randomized traffic against the reference model
        rnd_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0) c = 5'(17 + $urandom_range(3));
            else begin
                c = 5'($urandom_range(31));
                if (c >= 5'd17 && c <= 5'd20) c = 5'd0;
            end
            issue(c, rnd32(), rnd32(), 0, 32'd0, 1'b0);
            repeat ($urandom_range(2)) begin
                @(negedge clk);
                jitter();
            end
        end
        rnd_mode = 0;
        out_ready = 1'b1;
        retire = 1'b0;
        drain();

        // Reset in the middle of a multiply
        issue(5'd17, 32'd12345, 32'd678, 1, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        q.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("midmul_rst_out_valid", 64'(out_valid), 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        issue(5'd24, 32'd0, 32'd0, 1, 32'd0, 1'b0);
        repeat (40) @(negedge clk);
        issue(5'd0, 32'd100, 32'd23, 1, 32'd123, 1'b0);
        drain();

        // Carry from low to high half of the cycle counter
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
        @(negedge clk);
        release dut.cycle_cnt;
        @(negedge clk);
        issue(5'd23, 32'd0, 32'd0, 1, 32'd1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution unit that consumes the 5-bit ALU control code produced by the ALU control decoder and computes the operation result for the EX stage. Single-cycle arithmetic, logic, branch-compare, LUI and CSR-read codes complete in one cycle. The four M-extension multiply codes run on an iterative 32-step shift-add multiplier. The unit owns the 64-bit cycle and instret counters that back the RDCYCLE/RDINSTRET codes.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; handshake fires when in_valid & in_ready.
- alu_ctrl  input  5  operation code; encoding below.
- src1  input  32  operand 1 (rs1).
- src2  input  32  operand 2 (rs2 or immediate; for LUI, the already-shifted U-immediate).
- retire  input  1  one-cycle pulse per retired instruction.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result when out_valid & out_ready.
- result  output  32  registered result.
- branch_taken  output  1  registered compare outcome; valid with out_valid.

## Operation
- Codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
  - 16 LUI.
  - 17 MUL, 18 MULH, 19 MULHSU, 20 MULHU.
  - 21 RDINSTRETH, 22 RDINSTRET, 23 RDCYCLEH, 24 RDCYCLE.
  - 25–31: result 0, single cycle.
- Shifts use src2[4:0]. SLT/SLTU write 1 or 0.
- Branch codes: result = {31'b0, taken}, branch_taken = taken. branch_taken is 0 for all non-branch codes.
- LUI: result = src2.
- ADD/SUB wrap modulo 2^32.
- Multiply:
  - Form magnitudes of both operands. MULH treats both as signed; MULHSU treats src1 signed, src2 unsigned; MUL/MULHU treat both as unsigned.
  - 32 shift-add iterations into a 64-bit accumulator, then one sign-fix step (two's-complement negate when the operand signs differ).
  - MUL returns bits [31:0]; the others return [63:32].
- FSM states: IDLE, MUL (counter 0..31), SIGN, DONE.
  - IDLE → DONE on accept of a non-multiply code (result registered at the accept edge).
  - IDLE → MUL on accept of codes 17–20 (operands latched, counter = 0).
  - MUL → SIGN after the iteration with counter = 31.
  - SIGN → DONE.
  - DONE → IDLE on out_ready, unless a new op is accepted in the same cycle; the next state then follows the IDLE rules.
- in_ready = (state==IDLE) | (state==DONE & out_ready); forced to 0 while rst is high.
- out_valid = (state==DONE).
- Counters:
  - cycle_cnt: 64 bits, +1 every cycle when not in reset.
  - instret_cnt: 64 bits, +1 on each cycle with retire high.
  - Both wrap from 2^64−1 to 0.
  - CSR read codes return the counter value before the accept edge's own increment.
- Inputs other than in_valid/out_ready are ignored outside the accept cycle. Operands are not required to stay stable during a multiply.

## Timing
- Accept in cycle N:
  - Single-cycle codes: out_valid high in cycle N+1.
  - Multiply: iterations at the ends of N+1..N+32, sign-fix at the end of N+33, out_valid high in cycle N+34.
- Back-to-back single-cycle ops with out_ready held high give one result per cycle.
- The result and branch_taken registers do not change while out_valid=1 and out_ready=0.
- Reset (any state, including mid-multiply):
  - Next state IDLE.
  - out_valid=0, result=0, branch_taken=0.
  - Both counters 0; the in-flight op is discarded.
  - in_ready=1 in the first cycle after rst deasserts, and cycle_cnt reads 0 in that cycle.
- retire asserted during reset is ignored.

## Test plan
- ADD 0x7FFFFFFF+1 → 0x80000000; SUB 0−1 → 0xFFFFFFFF; SRA 0x80000000 by 31 → 0xFFFFFFFF. Each with out_valid exactly 1 cycle after accept.
- BLT src1=0xFFFFFFFF, src2=1 → taken=1; BLTU with same operands → taken=0; BEQ 5,5 → result=1.
- Multiply results, each with out_valid exactly 34 cycles after accept:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MUL, same operands → 0x00000001.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Hold out_ready=0 for 5 cycles after a result → result stable, in_ready=0, new in_valid not accepted. Raise out_ready together with in_valid → new op accepted in that same cycle.
- Release reset, pulse retire 3 times, then issue RDINSTRET → 3. Issue RDCYCLE at cycle K after reset → K. Preload/force cycle_cnt to 0xFFFFFFFF and issue RDCYCLEH the cycle after → 0x00000001.
- Assert rst at iteration 10 of a MUL → out_valid stays 0, and in_ready=1 the cycle after rst drops. A fresh ADD then completes correctly.
